jhash_issue_sched: RTL
======================

// Module: jhash_issue_sched
// PURPOSE
//  Schedules lookup requests from NREQ requesters (memcache key parsers) into the shared,
//  fixed-latency, non-stallable pipelined Jenkins hash core, at most one issue per ISSUE_GAP cycles.
//  The core has no valid/tag path, so this block carries {valid,id,tag} alongside it in a
//  LATENCY-deep delay line and returns each 32-bit hash tagged to the requester that issued it.
// PARAMETERS
//  NREQ       2    number of requesters (1..8)
//  TAGW       8    requester tag width, returned unchanged with the result
//  LATENCY    110  hash core latency: cycles from core_* inputs registered to core_hash valid
//  ISSUE_GAP  1    minimum cycles between issues (1 = every cycle; >1 holds core_k* stable longer)
// PORTS
//  CLK        in   1           clock
//  RST        in   1           synchronous reset, active-high
//  req_valid  in   NREQ        request pending, per requester
//  req_ready  out  NREQ        grant; handshake = req_valid[i] & req_ready[i] at CLK edge
//  req_len    in   NREQ*8      key length in bytes, slice i = [8*i+:8]
//  req_k0/1/2 in   NREQ*32     key words 0..2, slice i = [32*i+:32]
//  req_tag    in   NREQ*TAGW   opaque tag
//  core_len   out  8           registered key_length to hash core
//  core_k0/1/2 out 32          registered key words to hash core
//  core_hash  in   32          hash core result
//  res_valid  out  1           result strobe, one cycle, no backpressure
//  res_id     out  $clog2(NREQ) (min 1)  requester index of result
//  res_tag    out  TAGW        tag of result
//  res_hash   out  32          hash value
//  inflight   out  $clog2(LATENCY+3)  issued-but-not-returned count
// BEHAVIOUR
//  - Reset: res_valid=0, res_id=0, res_tag=0, res_hash=0, core_len=0, core_k*=0, inflight=0,
//    req_ready=0 during RST, gap counter=0, delay line valid bits all 0, rr pointer=NREQ-1.
//  - Issue allowed when gap counter==0. Then req_ready is combinational one-hot: first i with req_valid[i]
//    searching from (rr_ptr+1) mod NREQ upward with wrap. No valid -> req_ready=0, nothing issued.
//  - On handshake at edge t: core_len/core_k* <= granted request; rr_ptr <= i;
//    gap counter <= ISSUE_GAP-1; delay line stage 0 <= {1,i,tag}.
//    Gap counter decrements to 0 while nonzero; each cycle it is nonzero, req_ready=0.
//  - No issue: core_* hold last value (not zeroed); delay stage 0 valid <= 0.
//  - Delay line shifts every cycle, never stalls; depth LATENCY. At stage LATENCY-1 exit
//    (LATENCY edges after issue), registered: res_valid<=v, res_id, res_tag, res_hash<=core_hash.
//    Issue edge t -> res_valid high in cycle following edge t+LATENCY+1.
//  - Ordering: results in issue order; exactly one res_valid per handshake.
//  - inflight: +1 on issue, -1 on res_valid, unchanged if both in same cycle; never wraps
//    (max LATENCY+2).
//  - req_len passed unmodified (0 and 255 legal); no length checking here.
//  - req_valid may drop without handshake; no penalty. Requester holding valid is granted within NREQ issue slots.
//  - RST mid-operation: all in-flight entries dropped, no res_valid for them; core output
//    garbage during refill is masked by cleared valid bits.
// STRUCTURE
//  - jhash_pkg: JHASH_LATENCY=110 constant, JHASH_INIT=32'hDEADBEEF, typedef jhash_req_t
//    {len[7:0], k0, k1, k2}, typedef for delay-line entry {valid, id, tag}.
//  - Sub-module jhash_rr_arb (NREQ-wide round-robin, pointer input, one-hot grant output).
//  - Delay line as a register array of LATENCY entries inside this module; no RAM.
// TESTING
//  - Single: NREQ=2, req0 len=5 k0=0x11223344 tag=0xA5 at edge 10 -> core_len=5/core_k0 in
//    cycle after edge 10; res_valid at edge 121 only, res_id=0, res_tag=0xA5,
//    res_hash=core_hash sampled there.
//  - Fairness: both req_valid held 20 cycles -> grants alternate 0,1,0,1...; 20 results
//    in same order, tags intact; inflight peaks at 20.
//  - ISSUE_GAP=3, req0 always valid -> req_ready high every 3rd cycle; core_k* stable 3 cycles.
//  - Burst to steady state: one issue every cycle for 200 cycles -> inflight saturates at 111,
//    stays constant while issue and return coincide, results back-to-back, none lost.
//  - Reset at cycle 50 with 40 in flight -> no res_valid for 110 cycles after reset; inflight=0;
//    next new request returns normally after its latency.
//  - Idle: no req_valid -> res_valid never asserts; core_* hold last issued values.

Source files
------------

// File: rtl/jhash_issue_sched_pkg.sv
// Shared types and constants for the Jenkins hash issue scheduler.
// Delay-line entries use fixed maximum widths (8 requesters, 32-bit tag) so one typedef serves every build.
package jhash_pkg;

    localparam int          JHASH_LATENCY = 110;
    localparam logic [31:0] JHASH_INIT    = 32'hDEADBEEF;
    localparam int          JHASH_IDW_MAX = 3;
    localparam int          JHASH_TAGW_MAX = 32;

    typedef struct packed {
        logic [7:0]  len;
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] k2;
    } jhash_req_t;

    typedef struct packed {
        logic                      valid;
        logic [JHASH_IDW_MAX-1:0]  id;
        logic [JHASH_TAGW_MAX-1:0] tag;
    } jhash_dl_ent_t;

endpackage

// File: rtl/jhash_issue_sched_rr_arb.sv
// Round-robin arbiter: searches upward from ptr+1 with wrap and returns a one-hot grant
// plus the granted index. No request gives an all-zero grant.
module jhash_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/jhash_issue_sched.sv
// Issues requests into a fixed-latency Jenkins hash core and carries {valid,id,tag} alongside
// it in a LATENCY-deep delay line so each returning hash is tagged to its requester.
module jhash_issue_sched
    import jhash_pkg::*;
#(
    parameter int  NREQ      = 2,
    parameter int  TAGW      = 8,
    parameter int  LATENCY   = JHASH_LATENCY,
    parameter int  ISSUE_GAP = 1,
    localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW      = $clog2(LATENCY + 3),
    localparam int GAPW      = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*8-1:0]    req_len,
    input  logic [NREQ*32-1:0]   req_k0,
    input  logic [NREQ*32-1:0]   req_k1,
    input  logic [NREQ*32-1:0]   req_k2,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [7:0]           core_len,
    output logic [31:0]          core_k0,
    output logic [31:0]          core_k1,
    output logic [31:0]          core_k2,
    input  logic [31:0]          core_hash,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [TAGW-1:0]      res_tag,
    output logic [31:0]          res_hash,
    output logic [CNTW-1:0]      inflight
);

    logic [IDW-1:0]  rr_ptr;
    logic [GAPW-1:0] gap_cnt;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            issue;
    logic            ret;
    jhash_req_t      sel_req;
    logic [TAGW-1:0] sel_tag;
    jhash_req_t      core_q;
    jhash_dl_ent_t   iss_ent;
    jhash_dl_ent_t   dl [LATENCY];
    jhash_dl_ent_t   dl_out;
    logic            dl_unused;

    jhash_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake: request i transfers at a CLK edge where req_valid[i] & req_ready[i];
    // ready is one-hot, combinational, and held low during reset and while the gap counter runs.
    assign req_ready = (!RST && gap_cnt == '0) ? grant : '0;
    assign issue     = |req_ready;

    always_comb begin
        sel_req = '0;
        sel_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_req.len = req_len[8*i +: 8];
                sel_req.k0  = req_k0[32*i +: 32];
                sel_req.k1  = req_k1[32*i +: 32];
                sel_req.k2  = req_k2[32*i +: 32];
                sel_tag     = req_tag[TAGW*i +: TAGW];
            end
        end
    end

    // The entry register sits level with the core input registers; the delay line then tracks
    // the core's own LATENCY stages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr        <= IDW'(NREQ - 1);
            gap_cnt       <= '0;
            core_q        <= '0;
            iss_ent       <= '0;
        end else begin
            iss_ent <= '0;
            if (issue) begin
                core_q        <= sel_req;
                rr_ptr        <= grant_idx;
                gap_cnt       <= GAPW'(ISSUE_GAP - 1);
                iss_ent.valid <= 1'b1;
                iss_ent.id    <= JHASH_IDW_MAX'(grant_idx);
                iss_ent.tag   <= JHASH_TAGW_MAX'(sel_tag);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAPW'(1);
            end
        end
    end

    assign core_len = core_q.len;
    assign core_k0  = core_q.k0;
    assign core_k1  = core_q.k1;
    assign core_k2  = core_q.k2;

    // Only valid bits are cleared on reset; stale id/tag bits are masked by them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl[i].valid <= 1'b0;
            end
        end else begin
            dl[0] <= iss_ent;
            for (int i = 1; i < LATENCY; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    assign dl_out    = dl[LATENCY-1];
    assign ret       = dl_out.valid;
    assign dl_unused = ^{dl_out.id, dl_out.tag};

    always_ff @(posedge CLK) begin
        if (RST) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_tag   <= '0;
            res_hash  <= '0;
        end else begin
            res_valid <= ret;
            if (ret) begin
                res_id   <= dl_out.id[IDW-1:0];
                res_tag  <= dl_out.tag[TAGW-1:0];
                res_hash <= core_hash;
            end
        end
    end

    // Counts down on the edge the result is captured, so a steady issue stream holds it flat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   inflight <= inflight + CNTW'(1);
                2'b01:   inflight <= inflight - CNTW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
